// File: rtl/flat_stream_bridge_pkg.sv
// flat_stream_bridge_pkg
// Shared definitions for the flat stream bridge: the control FSM state
// encoding, the byte width of the host link and a ceiling-divide helper
// used to size the stimulus and response byte counts.
package flat_stream_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/flat_byte_serializer.sv
// flat_byte_serializer
// Response path of the bridge. On a capture strobe it loads the wrapper's
// output vector (zero-extended to whole bytes) into a shift register and
// streams it out least-significant byte first over a valid/ready link.
// Build option: FLAT_STREAM_BRIDGE_PARITY_EN appends one byte holding the
// XOR of all data bytes; m_last then marks that parity byte.
//
// Ports:
//   clk, rst   sole clock, synchronous active-high reset
//   capture    one-cycle strobe: load data_in and start a response
//   data_in    OUT_W-bit vector to be transmitted
//   m_valid    response byte valid (registered)
//   m_ready    consumer accepts the byte
//   m_data     response byte (bottom byte of the shift register)
//   m_last     final byte of the response (registered)
//   done       final handshake of the response is happening this cycle
module flat_byte_serializer
    import flat_stream_bridge_pkg::*;
#(
    parameter int OUT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [OUT_W-1:0]  data_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    output logic              done
);

    localparam int OUT_BYTES = ceil_div(OUT_W, BYTE_W);
    localparam int SHREG_W   = OUT_BYTES * BYTE_W;
`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
    localparam int RESP_BYTES = OUT_BYTES + 1;
`else
    localparam int RESP_BYTES = OUT_BYTES;
`endif
    localparam int CNT_W = $clog2(RESP_BYTES + 1);

    logic [SHREG_W-1:0] shreg;
    logic [SHREG_W-1:0] shreg_next;
    logic [SHREG_W-1:0] capture_ext;
    logic [CNT_W-1:0]   byte_cnt;
    logic               handshake;
`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
    logic [BYTE_W-1:0]  parity;
`endif

    assign handshake = m_valid && m_ready;
    assign done      = handshake && m_last;
    assign m_data    = shreg[BYTE_W-1:0];

    always_comb begin
        capture_ext              = '0;
        capture_ext[OUT_W-1:0]   = data_in;
    end

    // After the last data byte has been shifted out, the parity byte is
    // dropped into the bottom slot so m_data always reads shreg[7:0].
    always_comb begin
        shreg_next = shreg >> BYTE_W;
`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
        if (byte_cnt == CNT_W'(OUT_BYTES - 1)) begin
            shreg_next[BYTE_W-1:0] = parity ^ shreg[BYTE_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
            parity   <= '0;
`endif
        end else if (capture) begin
            shreg    <= capture_ext;
            byte_cnt <= '0;
            m_valid  <= 1'b1;
            m_last   <= (RESP_BYTES == 1);
`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
            parity   <= '0;
`endif
        end else if (handshake) begin
            if (m_last) begin
                m_valid  <= 1'b0;
                m_last   <= 1'b0;
                byte_cnt <= '0;
            end else begin
                shreg    <= shreg_next;
                byte_cnt <= byte_cnt + CNT_W'(1);
                m_last   <= (byte_cnt == CNT_W'(RESP_BYTES - 2));
`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
                parity   <= parity ^ shreg[BYTE_W-1:0];
`endif
            end
        end
    end

endmodule

// File: rtl/flat_stream_bridge.sv
// flat_stream_bridge
// Byte-stream bridge between a fuzzing host link and a flattened DUT
// wrapper. Stimulus bytes are assembled (LSB byte first) into a shadow
// vector which is copied to in_flat when the final byte arrives. After
// DUT_LAT settle cycles out_flat is captured and streamed back as bytes.
// Build option: FLAT_STREAM_BRIDGE_PARITY_EN (see flat_byte_serializer).
//
// Ports:
//   clk, rst           sole clock, synchronous active-high reset
//   s_valid/s_ready    stimulus byte handshake, s_data the byte
//   in_flat            IN_W-bit vector driven into the wrapper
//   out_flat           OUT_W-bit vector returned by the wrapper
//   m_valid/m_ready    response byte handshake, m_data the byte
//   m_last             final byte of the response
//   busy               high whenever the FSM is not in LOAD
module flat_stream_bridge
    import flat_stream_bridge_pkg::*;
#(
    parameter int IN_W    = 11,
    parameter int OUT_W   = 24,
    parameter int DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    output logic [IN_W-1:0]   in_flat,
    input  logic [OUT_W-1:0]  out_flat,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int IN_BYTES = ceil_div(IN_W, BYTE_W);
    localparam int SHADOW_W = IN_BYTES * BYTE_W;
    localparam int IN_CNT_W = $clog2(IN_BYTES + 1);
    localparam int WAIT_W   = $clog2(DUT_LAT + 2);

    state_t              state;
    logic [SHADOW_W-1:0] shadow;
    logic [SHADOW_W-1:0] shadow_next;
    logic [IN_CNT_W-1:0] in_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                capture;
    logic                done;

    // Handshake outputs decode only from the state register (and reset),
    // so there is no combinational path from m_ready to s_ready.
    assign s_ready = (state == LOAD) && !rst;
    assign busy    = (state != LOAD);
    assign accept  = s_valid && s_ready;
    assign capture = (state == WAIT) && (wait_cnt == '0);

    // Shadow with the incoming byte merged in, so the final byte can be
    // copied to in_flat on the same edge it is accepted.
    always_comb begin
        shadow_next = shadow;
        shadow_next[int'(in_cnt) * BYTE_W +: BYTE_W] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            shadow   <= '0;
            in_cnt   <= '0;
            wait_cnt <= '0;
            in_flat  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        shadow <= shadow_next;
                        if (in_cnt == IN_CNT_W'(IN_BYTES - 1)) begin
                            in_flat  <= shadow_next[IN_W-1:0];
                            in_cnt   <= '0;
                            wait_cnt <= WAIT_W'(DUT_LAT);
                            state    <= WAIT;
                        end else begin
                            in_cnt <= in_cnt + IN_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (capture) begin
                        state <= SEND;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                SEND: begin
                    if (done) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    flat_byte_serializer #(
        .OUT_W (OUT_W)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .data_in (out_flat),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (done)
    );

endmodule

// File: tb/tb_flat_stream_bridge.sv
// tb_flat_stream_bridge
// Two bridge instances: index 0 with DUT_LAT=0 and a combinational stub
// (out_flat = zero-extended in_flat), index 1 with DUT_LAT=2 and a
// two-stage registered stub. Directed vectors with hand-computed results.
module tb_flat_stream_bridge;

`ifdef FLAT_STREAM_BRIDGE_PARITY_EN
    localparam int NRESP = 4;
`else
    localparam int NRESP = 3;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      s_valid = '0;
    logic [1:0][7:0] s_data = '0;
    logic [1:0]      m_ready = '0;
    wire  [1:0]      s_ready;
    wire  [1:0]      m_valid;
    wire  [1:0]      m_last;
    wire  [1:0]      busy;
    wire  [1:0][7:0] m_data;
    wire  [1:0][10:0] in_flat;
    wire  [23:0]     out_flat0;
    wire  [23:0]     out_flat1;
    logic [10:0]     stage1 = '0;
    logic [10:0]     stage2 = '0;

    int        checks = 0;
    int        failures = 0;
    int        cyc = 0;
    int        acc_cyc = 0;
    int        first_valid_cyc = 0;
    logic [7:0] rx_data [4];
    logic       rx_last [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_flat0 = {13'b0, in_flat[0]};
    always @(posedge clk) begin
        stage1 <= in_flat[1];
        stage2 <= stage1;
    end
    assign out_flat1 = {13'b0, stage2};

    flat_stream_bridge #(.IN_W(11), .OUT_W(24), .DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .in_flat(in_flat[0]), .out_flat(out_flat0),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
        .m_last(m_last[0]), .busy(busy[0])
    );

    flat_stream_bridge #(.IN_W(11), .OUT_W(24), .DUT_LAT(2)) dut1 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .in_flat(in_flat[1]), .out_flat(out_flat1),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
        .m_last(m_last[1]), .busy(busy[1])
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input int u, input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        s_valid[u] = 1'b1;
        s_data[u]  = b;
        while (!s_ready[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        s_valid[u] = 1'b0;
    endtask

    // Sends two stimulus bytes and checks the vector presented to the wrapper.
    task automatic applyStimulus(input int u, input logic [7:0] b0,
                                 input logic [7:0] b1, input logic [10:0] exp_flat);
        sendByte(u, b0);
        sendByte(u, b1);
        checkOutput("in_flat_update", 32'(in_flat[u]), 32'(exp_flat));
        checkOutput("busy_after_load", 32'(busy[u]), 32'd1);
    endtask

    // Collects n response bytes; optionally stalls m_ready for stall_len
    // cycles while byte stall_idx is presented, checking it stays stable.
    task automatic receive(input int u, input int n, input int stall_idx,
                           input int stall_len, input logic [7:0] stall_exp);
        int got = 0;
        int guard = 0;
        int stalled = 0;
        while (got < n && guard < 100) begin
            @(negedge clk);
            guard++;
            if (m_valid[u]) begin
                if (got == 0) first_valid_cyc = cyc;
                checkOutput("s_ready_in_send", 32'(s_ready[u]), 32'd0);
                if (got == stall_idx && stalled < stall_len) begin
                    m_ready[u] = 1'b0;
                    if (stalled > 0) begin
                        checkOutput("stall_m_valid", 32'(m_valid[u]), 32'd1);
                        checkOutput("stall_m_data", 32'(m_data[u]), 32'(stall_exp));
                    end
                    stalled++;
                end else begin
                    m_ready[u]   = 1'b1;
                    rx_data[got] = m_data[u];
                    rx_last[got] = m_last[u];
                    got++;
                    if (got == n) s_valid[u] = 1'b0;
                end
            end else begin
                m_ready[u] = 1'b0;
            end
        end
        if (guard >= 100) checkOutput("response_timeout", 32'(got), 32'(n));
        @(posedge clk);
        #1;
        m_ready[u] = 1'b0;
    endtask

    task automatic checkResponse(input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] ep);
        logic [7:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = ep;
        for (int i = 0; i < NRESP; i++) begin
            checkOutput($sformatf("resp_byte%0d", i), 32'(rx_data[i]), 32'(exp[i]));
            checkOutput($sformatf("resp_last%0d", i), 32'(rx_last[i]),
                        (i == NRESP - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        $display("[TB] start, response length %0d bytes", NRESP);
        repeat (2) @(negedge clk);
        checkOutput("s_ready_in_reset", 32'(s_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_flat", 32'(in_flat[0]), 32'd0);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_m_data", 32'(m_data[0]), 32'd0);
        checkOutput("reset_m_last", 32'(m_last), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd3);

        // Basic transaction, combinational stub.
        applyStimulus(0, 8'hAB, 8'h05, 11'h5AB);
        receive(0, NRESP, -1, 0, 8'h00);
        checkResponse(8'hAB, 8'h05, 8'h00, 8'hAE);
        checkOutput("latency_lat0", 32'(first_valid_cyc - acc_cyc + 1), 32'd2);

        // Backpressure on the second response byte.
        applyStimulus(0, 8'h34, 8'h02, 11'h234);
        receive(0, NRESP, 1, 6, 8'h02);
        checkResponse(8'h34, 8'h02, 8'h00, 8'h36);

        // DUT_LAT=2 with the registered stub.
        applyStimulus(1, 8'h7E, 8'h03, 11'h37E);
        receive(1, NRESP, -1, 0, 8'h00);
        checkResponse(8'h7E, 8'h03, 8'h00, 8'h7D);
        checkOutput("latency_lat2", 32'(first_valid_cyc - acc_cyc + 1), 32'd4);

        // 0xFF offered throughout SEND must be ignored.
        applyStimulus(0, 8'h11, 8'h01, 11'h111);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hFF;
        receive(0, NRESP, -1, 0, 8'h00);
        checkResponse(8'h11, 8'h01, 8'h00, 8'h10);
        checkOutput("in_flat_held", 32'(in_flat[0]), 32'h111);
        applyStimulus(0, 8'h22, 8'h03, 11'h322);
        receive(0, NRESP, -1, 0, 8'h00);
        checkResponse(8'h22, 8'h03, 8'h00, 8'h21);

        // Reset after the first response byte aborts the transaction.
        applyStimulus(0, 8'h5A, 8'h06, 11'h65A);
        receive(0, 1, -1, 0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_m_valid", 32'(m_valid[0]), 32'd0);
        checkOutput("abort_in_flat", 32'(in_flat[0]), 32'd0);
        checkOutput("abort_busy", 32'(busy[0]), 32'd0);
        checkOutput("abort_m_last", 32'(m_last[0]), 32'd0);
        applyStimulus(0, 8'hC3, 8'h07, 11'h7C3);
        receive(0, NRESP, -1, 0, 8'h00);
        checkResponse(8'hC3, 8'h07, 8'h00, 8'hC4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
